mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter with fixed 3-cycle access
//
// Purpose: arbitrates a synchronous-read memory between requester 0 (CPU) and
// requester 1 (auxiliary/debug). Each access runs IDLE -> ISSUE -> RESP:
// the winner's fields are captured on the grant edge, driven to memory in
// ISSUE, and acknowledged with a one-cycle ack in RESP.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0/1, we0/1               access request (held until ack), write select
//   addr0/1, wdata0/1           requester address and write data
//   gnt0/1                      winner owns memory during ISSUE and RESP
//   ack0/1                      one-cycle completion pulse in RESP
//   rdata0/1                    mem_rdata pass-through, valid while ackN=1
//   mem_we, mem_addr, mem_wdata memory command (mem_we only in ISSUE)
//   mem_rdata                   memory read data, one cycle after address
//   busy                        high whenever the FSM is not IDLE
//
// Configuration macro: MEM_ARB_FIXED_PRIO_EN
//   undefined (default): round-robin arbitration with a last-granted pointer
//   defined:             fixed priority, port 0 wins every contention

module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              gnt1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              win_q, win_d;       // index of the requester being served
    logic              we_q, we_d;
    // The memory address/data registers double as the latched request fields:
    // loaded only on the grant edge, they hold their value outside ISSUE.
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              pick;               // winner if a grant happens this cycle

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = ~req0;
    end
`else
    logic last_q, last_d;                  // last granted port

    // Under contention the port not granted last wins; a lone requester wins.
    always_comb begin
        pick = (req0 & req1) ? ~last_q : req1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d     = ISSUE;
                    win_d       = pick;
                    we_d        = pick ? we1 : we0;
                    mem_addr_d  = pick ? addr1 : addr0;
                    mem_wdata_d = pick ? wdata1 : wdata0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d      = pick;
`endif
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;           // port 0 wins the first contention
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_we    = (state_q == ISSUE) & we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign gnt0      = busy & ~win_q;
    assign gnt1      = busy & win_q;
    assign ack0      = (state_q == RESP) & ~win_q;
    assign ack1      = (state_q == RESP) & win_q;
    assign rdata0    = mem_rdata;
    assign rdata1    = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, ack0, gnt1, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
        .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Synchronous-read memory model
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single uncontended access from one port; leaves the bench in IDLE.
    task automatic access(input logic port, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
    endtask

    logic exp_port;

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        @(negedge clk);
        step();

        // Reset state
        check("rst_gnt",   32'({gnt0, gnt1}), 0);
        check("rst_ack",   32'({ack0, ack1}), 0);
        check("rst_we",    32'(mem_we), 0);
        check("rst_addr",  32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_busy",  32'(busy), 0);
        rst = 1'b0;

        // Write 0x00AB to addr 5 from port 0
        req0 = 1; we0 = 1; addr0 = 5; wdata0 = 16'h00AB;
        step();
        check("wr_issue_gnt",   32'({gnt0, gnt1}), 2'b10);
        check("wr_issue_we",    32'(mem_we), 1);
        check("wr_issue_addr",  32'(mem_addr), 5);
        check("wr_issue_wdata", 32'(mem_wdata), 16'h00AB);
        check("wr_issue_ack",   32'({ack0, ack1}), 0);
        check("wr_issue_busy",  32'(busy), 1);
        req0 = 0;  // early drop must not abort the access
        step();
        check("wr_resp_ack", 32'({ack0, ack1}), 2'b10);
        check("wr_resp_gnt", 32'({gnt0, gnt1}), 2'b10);
        check("wr_resp_we",  32'(mem_we), 0);
        step();
        check("wr_idle_busy", 32'(busy), 0);
        check("wr_idle_ack",  32'({ack0, ack1}), 0);
        check("wr_idle_addr", 32'(mem_addr), 5);

        // Read back addr 5 on port 0
        req0 = 1; we0 = 0; addr0 = 5;
        step();
        check("rd_issue_we",   32'(mem_we), 0);
        check("rd_issue_addr", 32'(mem_addr), 5);
        req0 = 0;
        step();
        check("rd_resp_ack",   32'({ack0, ack1}), 2'b10);
        check("rd_resp_rdata", 32'(rdata0), 16'h00AB);
        step();

        // Preload memory[3] and memory[9]
        access(1'b1, 1'b1, 6'd3, 16'h1234);
        access(1'b0, 1'b1, 6'd9, 16'h9999);

        // Port 1 read of addr 3, address changed to 9 during ISSUE
        req1 = 1; we1 = 0; addr1 = 3;
        step();
        check("chg_issue_gnt",  32'({gnt0, gnt1}), 2'b01);
        check("chg_issue_addr", 32'(mem_addr), 3);
        addr1 = 9; we1 = 1; wdata1 = 16'hDEAD;
        step();
        check("chg_resp_ack",   32'({ack0, ack1}), 2'b01);
        check("chg_resp_rdata", 32'(rdata1), 16'h1234);
        check("chg_resp_addr",  32'(mem_addr), 3);
        req1 = 0; we1 = 0;
        step();

        // Continuous contention: last grant was port 1, so port 0 goes first
        req0 = 1; we0 = 0; addr0 = 5;
        req1 = 1; we1 = 0; addr1 = 3;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_port = 1'b0;
`else
            exp_port = (i % 2 == 1);
`endif
            step();
            check($sformatf("rr%0d_gnt", i), 32'({gnt0, gnt1}), exp_port ? 2'b01 : 2'b10);
            check($sformatf("rr%0d_issue_ack", i), 32'({ack0, ack1}), 0);
            step();
            check($sformatf("rr%0d_ack", i), 32'({ack0, ack1}), exp_port ? 2'b01 : 2'b10);
            check($sformatf("rr%0d_rdata", i), 32'(exp_port ? rdata1 : rdata0),
                  exp_port ? 16'h1234 : 16'h00AB);
            step();
            check($sformatf("rr%0d_idle", i), 32'({busy, ack0, ack1}), 0);
        end
        req0 = 0; req1 = 0;

        // Make port 0 the last grant, then reset in ISSUE of a write
        access(1'b0, 1'b0, 6'd5, 16'h0);
        req0 = 1; we0 = 1; addr0 = 7; wdata0 = 16'h7777;
        step();
        check("rstiss_we", 32'(mem_we), 1);
        rst = 1; req0 = 0;
        step();
        rst = 0;
        check("rstiss_we_after",   32'(mem_we), 0);
        check("rstiss_busy_after", 32'(busy), 0);
        check("rstiss_ack_after",  32'({ack0, ack1}), 0);
        check("rstiss_gnt_after",  32'({gnt0, gnt1}), 0);
        step();
        check("rstiss_no_ack",     32'({ack0, ack1}), 0);
        req0 = 1; we0 = 0; addr0 = 5;
        req1 = 1; we1 = 0; addr1 = 3;
        step();
        check("rstiss_contend_gnt", 32'({gnt0, gnt1}), 2'b10);
        req0 = 0; req1 = 0;
        step();
        check("rstiss_contend_ack", 32'({ack0, ack1}), 2'b10);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Never two grants or two acks in any cycle
    always @(negedge clk) begin
        if (!rst && ((gnt0 && gnt1) || (ack0 && ack1))) begin
            tests_run++;
            tests_failed++;
            $display("FAIL onehot: gnt=%b%b ack=%b%b expected at most one of each",
                     gnt0, gnt1, ack0, ack1);
        end
    end

endmodule
